// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: tracks Res/A3 tags through E/M/W, derives stall and
// forwarding selects from the Tuse/Tnew rule, and owns the mult/div busy counter.
module hazard_scoreboard #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       EXC_flush,
    input  logic [4:0] A1_D,
    input  logic [4:0] A2_D,
    input  logic [4:0] A3_D,
    input  logic [1:0] Res_D,
    input  logic [1:0] Tuse_rs_D,
    input  logic [1:0] Tuse_rt_D,
    input  logic       MDstart_D,
    input  logic       MDdiv_D,
    input  logic       MDuse_D,
    output logic       stall,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic       fwd_rt_M,
    output logic       md_busy
);
    localparam logic [1:0] RES_NW  = 2'b00;
    localparam logic [1:0] RES_ALU = 2'b01;
    localparam logic [1:0] RES_DM  = 2'b10;
    localparam logic [1:0] RES_PC  = 2'b11;

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW     = $clog2(MD_MAX + 1);

    logic [4:0]    r_a1_e, r_a2_e, r_a3_e;
    logic [1:0]    r_res_e;
    logic          r_md_e, r_div_e;
    logic [4:0]    r_a2_m, r_a3_m;
    logic [1:0]    r_res_m;
    logic [4:0]    r_a2_w, r_a3_w;
    logic [1:0]    r_res_w;
    logic [CW-1:0] r_cnt;

    logic [1:0] w_tnew_e, w_tnew_m;
    logic       w_stall_rs, w_stall_rt, w_stall_md;

    function automatic logic f_match(input logic [4:0] a3, input logic [1:0] res,
                                     input logic [4:0] r);
        return (a3 == r) && (r != 5'd0) && (res != RES_NW);
    endfunction

    // Nearest matching stage wins; if it is not ready yet the farther stages
    // are ignored and the select stays at the register-file/pipe value.
    function automatic logic [1:0] f_fwd_d(input logic [4:0] r);
        logic [1:0] sel;
        sel = 2'b00;
        if (f_match(r_a3_e, r_res_e, r)) begin
            if (r_res_e == RES_PC) sel = 2'b01;
        end else if (f_match(r_a3_m, r_res_m, r)) begin
            if (r_res_m == RES_ALU || r_res_m == RES_PC) sel = 2'b10;
        end else if (f_match(r_a3_w, r_res_w, r)) begin
            sel = 2'b11;
        end
        return sel;
    endfunction

    function automatic logic [1:0] f_fwd_e(input logic [4:0] r);
        logic [1:0] sel;
        sel = 2'b00;
        if (f_match(r_a3_m, r_res_m, r)) begin
            if (r_res_m == RES_ALU || r_res_m == RES_PC) sel = 2'b10;
        end else if (f_match(r_a3_w, r_res_w, r)) begin
            sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        w_tnew_e = 2'd0;
        w_tnew_m = 2'd0;
        case (r_res_e)
            RES_ALU: w_tnew_e = 2'd1;
            RES_DM:  w_tnew_e = 2'd2;
            default: w_tnew_e = 2'd0;
        endcase
        if (r_res_m == RES_DM) w_tnew_m = 2'd1;
    end

    always_comb begin
        w_stall_rs = (f_match(r_a3_e, r_res_e, A1_D) && (w_tnew_e > Tuse_rs_D)) ||
                     (f_match(r_a3_m, r_res_m, A1_D) && (w_tnew_m > Tuse_rs_D));
        w_stall_rt = (f_match(r_a3_e, r_res_e, A2_D) && (w_tnew_e > Tuse_rt_D)) ||
                     (f_match(r_a3_m, r_res_m, A2_D) && (w_tnew_m > Tuse_rt_D));
        w_stall_md = MDuse_D && (md_busy || r_md_e);
        stall      = w_stall_rs || w_stall_rt || w_stall_md;
        fwd_rs_D   = f_fwd_d(A1_D);
        fwd_rt_D   = f_fwd_d(A2_D);
        fwd_rs_E   = f_fwd_e(r_a1_e);
        fwd_rt_E   = f_fwd_e(r_a2_e);
        fwd_rt_M   = f_match(r_a3_w, r_res_w, r_a2_m);
        md_busy    = (r_cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (reset || EXC_flush) begin
            r_a1_e  <= '0;
            r_a2_e  <= '0;
            r_a3_e  <= '0;
            r_res_e <= RES_NW;
            r_md_e  <= 1'b0;
            r_div_e <= 1'b0;
            r_a2_m  <= '0;
            r_a3_m  <= '0;
            r_res_m <= RES_NW;
            r_a2_w  <= '0;
            r_a3_w  <= '0;
            r_res_w <= RES_NW;
        end else begin
            if (stall) begin
                r_a1_e  <= '0;
                r_a2_e  <= '0;
                r_a3_e  <= '0;
                r_res_e <= RES_NW;
                r_md_e  <= 1'b0;
                r_div_e <= 1'b0;
            end else begin
                r_a1_e  <= A1_D;
                r_a2_e  <= A2_D;
                r_a3_e  <= A3_D;
                r_res_e <= Res_D;
                r_md_e  <= MDstart_D;
                r_div_e <= MDdiv_D;
            end
            r_a2_m  <= r_a2_e;
            r_a3_m  <= r_a3_e;
            r_res_m <= r_res_e;
            r_a2_w  <= r_a2_m;
            r_a3_w  <= r_a3_m;
            r_res_w <= r_res_m;
        end
    end

    // A flush kills the start flag but never an operation already counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_md_e && !EXC_flush) begin
            r_cnt <= r_div_e ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a driver pushes reference-model
// expectations per cycle, a monitor pops and compares on the falling edge.
module tb_hazard_scoreboard;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic       clk = 1'b0;
    logic       reset, EXC_flush;
    logic [4:0] A1_D, A2_D, A3_D;
    logic [1:0] Res_D, Tuse_rs_D, Tuse_rt_D;
    logic       MDstart_D, MDdiv_D, MDuse_D;
    logic       stall, fwd_rt_M, md_busy;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

    always #5 clk = ~clk;

    hazard_scoreboard #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .EXC_flush(EXC_flush),
        .A1_D(A1_D), .A2_D(A2_D), .A3_D(A3_D), .Res_D(Res_D),
        .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
        .MDstart_D(MDstart_D), .MDdiv_D(MDdiv_D), .MDuse_D(MDuse_D),
        .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
        .md_busy(md_busy)
    );

    typedef struct {
        int a1, a2, a3, res;
        bit md, dv;
    } ins_t;

    typedef struct {
        int tuse_rs, tuse_rt;
        bit mduse, rst, fl;
    } ctl_t;

    typedef struct {
        string name;
        bit    stall;
        int    frsd, frtd, frse, frte;
        bit    frtm, busy;
    } exp_t;

    // Reference model: pipe[0]=E, pipe[1]=M, pipe[2]=W; cnt = cycles of busy left.
    ins_t pipe[3];
    int   cnt;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   last_stall;

    ins_t din;
    ctl_t ctl;

    function automatic bit m_match(ins_t i, int r);
        return i.a3 == r && r != 0 && i.res != 0;
    endfunction

    // Cycles until the result exists, given how many stages past E it is.
    function automatic int m_tnew(int res, int age);
        int base;
        base = (res == 1) ? 1 : (res == 2) ? 2 : 0;
        return (base > age) ? base - age : 0;
    endfunction

    function automatic int m_fwd(int r, int from);
        for (int a = from; a < 3; a++)
            if (m_match(pipe[a], r))
                return (m_tnew(pipe[a].res, a) == 0) ? a + 1 : 0;
        return 0;
    endfunction

    function automatic bit m_stall_reg(int r, int tuse);
        for (int a = 0; a < 2; a++)
            if (m_match(pipe[a], r) && m_tnew(pipe[a].res, a) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input string nm, input bit chk);
        exp_t e;
        ins_t bubble;
        A1_D = 5'(din.a1); A2_D = 5'(din.a2); A3_D = 5'(din.a3); Res_D = 2'(din.res);
        MDstart_D = din.md; MDdiv_D = din.dv;
        Tuse_rs_D = 2'(ctl.tuse_rs); Tuse_rt_D = 2'(ctl.tuse_rt);
        MDuse_D = ctl.mduse; reset = ctl.rst; EXC_flush = ctl.fl;

        e.name  = nm;
        e.stall = m_stall_reg(din.a1, ctl.tuse_rs) || m_stall_reg(din.a2, ctl.tuse_rt) ||
                  (ctl.mduse && (cnt > 0 || pipe[0].md));
        e.frsd  = m_fwd(din.a1, 0);
        e.frtd  = m_fwd(din.a2, 0);
        e.frse  = m_fwd(pipe[0].a1, 1);
        e.frte  = m_fwd(pipe[0].a2, 1);
        e.frtm  = m_match(pipe[2], pipe[1].a2);
        e.busy  = cnt > 0;
        last_stall = e.stall;
        if (chk) sb.push_back(e);

        @(posedge clk);
        bubble = '{0, 0, 0, 0, 1'b0, 1'b0};
        if (ctl.rst) begin
            pipe = '{bubble, bubble, bubble};
            cnt  = 0;
        end else begin
            if (pipe[0].md && !ctl.fl) cnt = pipe[0].dv ? DIV_CYCLES : MULT_CYCLES;
            else if (cnt > 0) cnt--;
            if (ctl.fl) pipe = '{bubble, bubble, bubble};
            else begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = e.stall ? bubble : din;
            end
        end
        #1;
    endtask

    task automatic set_d(input int a1, input int a2, input int a3, input int res,
                         input int trs, input int trt, input bit md, input bit dv,
                         input bit mdu);
        din = '{a1, a2, a3, res, md, dv};
        ctl = '{trs, trt, mdu, 1'b0, 1'b0};
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            set_d(0, 0, 0, 0, 3, 3, 0, 0, 0);
            step("nop", 1'b1);
        end
    endtask

    // Monitor: outputs are combinational, so one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (stall !== e.stall || fwd_rs_D !== 2'(e.frsd) || fwd_rt_D !== 2'(e.frtd) ||
                    fwd_rs_E !== 2'(e.frse) || fwd_rt_E !== 2'(e.frte) ||
                    fwd_rt_M !== e.frtm || md_busy !== e.busy) begin
                    n_bad++;
                    $display("FAIL %s t=%0t got stall=%b fD=%b/%b fE=%b/%b fM=%b busy=%b want stall=%b fD=%0d/%0d fE=%0d/%0d fM=%b busy=%b",
                             e.name, $time, stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
                             fwd_rt_M, md_busy, e.stall, e.frsd, e.frtd, e.frse, e.frte,
                             e.frtm, e.busy);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        din = '{0, 0, 0, 0, 1'b0, 1'b0};
        ctl = '{3, 3, 1'b0, 1'b1, 1'b0};
        cnt = 0;
        pipe[0] = din; pipe[1] = din; pipe[2] = din;
        #1;
        step("reset_x", 1'b0);
        step("reset_state", 1'b1);
        step("reset_state", 1'b1);
        nops(3);

        // lw $1 ; addu $2,$1,$3 : one stall, then W-forward into E
        set_d(5, 0, 1, 2, 1, 3, 0, 0, 0); step("lu_lw", 1'b1);
        set_d(1, 3, 2, 1, 1, 1, 0, 0, 0); step("lu_stall", 1'b1);
        step("lu_release", 1'b1);
        nops(1);
        nops(2);

        // addu $1 ; nop ; beq $1 : M forward to D
        set_d(4, 5, 1, 1, 1, 1, 0, 0, 0); step("alu_wr", 1'b1);
        nops(1);
        set_d(1, 6, 0, 0, 0, 0, 0, 0, 0); step("beq_fwdM", 1'b1);
        nops(3);

        // jal ; jr $31 : E forward of PC+8
        set_d(0, 0, 31, 3, 3, 3, 0, 0, 0); step("jal", 1'b1);
        set_d(31, 0, 0, 0, 0, 3, 0, 0, 0); step("jr_fwdE", 1'b1);
        nops(3);

        // writes to $0 never match
        for (int i = 0; i < 3; i++) begin
            set_d(2, 3, 0, 1, 1, 1, 0, 0, 0); step("zero_wr", 1'b1);
        end
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0); step("zero_rd", 1'b1);
        nops(3);

        // div ; mfhi held until the divider drains
        set_d(4, 5, 0, 0, 1, 1, 1, 1, 1); step("div", 1'b1);
        guard = 0;
        do begin
            set_d(0, 0, 7, 1, 3, 3, 0, 0, 1); step("mfhi_hold", 1'b1);
            guard++;
        end while (last_stall && guard < 30);
        nops(2);

        // mult ; lw ; flush while lw in E
        set_d(4, 5, 0, 0, 1, 1, 1, 0, 1); step("mult", 1'b1);
        set_d(6, 0, 1, 2, 1, 3, 0, 0, 0); step("lw_pre_flush", 1'b1);
        set_d(1, 1, 2, 1, 0, 0, 0, 0, 0); ctl.fl = 1'b1; step("flush", 1'b1);
        set_d(1, 1, 2, 1, 0, 0, 0, 0, 0); step("post_flush", 1'b1);
        nops(8);

        for (int i = 0; i < 600; i++) begin
            bit md;
            md  = ($urandom_range(0, 9) == 0);
            din = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    md, 1'($urandom_range(0, 1))};
            if ($urandom_range(0, 15) == 0) din.a3 = 31;
            if ($urandom_range(0, 15) == 0) din.a1 = 31;
            ctl = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    md || ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 149) == 0), ($urandom_range(0, 29) == 0)};
            step("random", 1'b1);
        end
        nops(1);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
